// File: rtl/scurve_usb_arbiter.sv
// Round-robin packet-framing arbiter from two 16-bit source FIFOs into the USB data FIFO.
// Bursts are framed as {HDR_TAG[15:1], src}, data words, then {4'hF, word_count}.
module scurve_usb_arbiter #(
   parameter int unsigned BURST_MAX = 256,
   parameter logic [15:0] HDR_TAG   = 16'hA5A0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  src_enable,
   input  logic        src0_fifo_empty,
   input  logic        src1_fifo_empty,
   input  logic [15:0] src0_fifo_dout,
   input  logic [15:0] src1_fifo_dout,
   output logic        src0_fifo_rd_en,
   output logic        src1_fifo_rd_en,
   input  logic        usb_data_fifo_full,
   output logic        usb_data_fifo_wr_en,
   output logic [15:0] usb_data_fifo_wr_din,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        packet_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      READ    = 2'd2,
      TRAILER = 2'd3
   } state_t;

   localparam logic [11:0] BURST_LIM = 12'(BURST_MAX);

   state_t      state;
   logic        cur_src;
   logic        last_grant;
   logic [11:0] issued;
   logic [11:0] written;
   logic        stopped;
   logic        in_flight;
   logic        skid_valid;
   logic [15:0] skid_data;

   logic [1:0]  req;
   logic        pick;
   logic        cur_empty;
   logic [15:0] cur_dout;
   logic        issue_ctx;
   logic        issue;
   logic        stop_now;
   logic        read_done;
   logic        hdr_wr;
   logic        data_wr;
   logic        trl_wr;
   logic        skid_load;
   logic        skid_drain;

   assign req  = src_enable & ~{src1_fifo_empty, src0_fifo_empty};
   // Single requester wins outright; on a tie the source that did not go last wins.
   assign pick = req[1] & (~req[0] | ~last_grant);

   assign cur_empty = cur_src ? src1_fifo_empty : src0_fifo_empty;
   assign cur_dout  = cur_src ? src1_fifo_dout  : src0_fifo_dout;

   assign issue_ctx = (state == READ) & ~usb_data_fifo_full & ~skid_valid & ~stopped;
   assign issue     = issue_ctx & ~cur_empty & (issued != BURST_LIM);
   assign stop_now  = issue_ctx & (cur_empty | (issued == BURST_LIM));

   // The last returned word may still be written in the same cycle we decide to leave READ.
   assign read_done = (stopped | stop_now) & ~skid_valid & (~in_flight | ~usb_data_fifo_full);

   assign hdr_wr     = (state == HEADER)  & ~usb_data_fifo_full;
   assign data_wr    = (state == READ)    & ~usb_data_fifo_full & (skid_valid | in_flight);
   assign trl_wr     = (state == TRAILER) & ~usb_data_fifo_full;
   assign skid_load  = (state == READ)    &  usb_data_fifo_full & in_flight;
   assign skid_drain = skid_valid & ~usb_data_fifo_full;

   assign src0_fifo_rd_en     = issue & ~cur_src;
   assign src1_fifo_rd_en     = issue &  cur_src;
   assign usb_data_fifo_wr_en = hdr_wr | data_wr | trl_wr;
   assign packet_done         = trl_wr;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      usb_data_fifo_wr_din = 16'h0000;
      case (state)
         HEADER:  usb_data_fifo_wr_din = {HDR_TAG[15:1], cur_src};
         READ:    if (data_wr) usb_data_fifo_wr_din = skid_valid ? skid_data : cur_dout;
         TRAILER: usb_data_fifo_wr_din = {4'hF, written};
         default: usb_data_fifo_wr_din = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 2'b00;
         busy       <= 1'b0;
         cur_src    <= 1'b0;
         last_grant <= 1'b1;
         issued     <= 12'd0;
         written    <= 12'd0;
         stopped    <= 1'b0;
         in_flight  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; later ones override earlier.
         in_flight <= issue;
         if (issue)    issued  <= issued + 12'd1;
         if (data_wr)  written <= written + 12'd1;
         if (stop_now) stopped <= 1'b1;
         if (skid_load)       skid_valid <= 1'b1;
         else if (skid_drain) skid_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (|req) begin
                  cur_src <= pick;
                  grant   <= pick ? 2'b10 : 2'b01;
                  busy    <= 1'b1;
                  issued  <= 12'd0;
                  written <= 12'd0;
                  stopped <= 1'b0;
                  state   <= HEADER;
               end
            end
            HEADER: begin
               if (hdr_wr) state <= READ;
            end
            READ: begin
               if (read_done) state <= TRAILER;
            end
            TRAILER: begin
               if (trl_wr) begin
                  last_grant <= cur_src;
                  grant      <= 2'b00;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: pure data register, qualified by skid_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (skid_load) skid_data <= cur_dout;
   end

endmodule

// File: tb/tb_scurve_usb_arbiter.sv
// Directed bench for scurve_usb_arbiter: behavioural source FIFOs, USB write log, protocol monitor.
module tb_scurve_usb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  src_enable;
   logic        src0_fifo_empty, src1_fifo_empty;
   logic [15:0] src0_fifo_dout = 16'h0000;
   logic [15:0] src1_fifo_dout = 16'h0000;
   logic        src0_fifo_rd_en, src1_fifo_rd_en;
   logic        usb_data_fifo_full;
   logic        usb_data_fifo_wr_en;
   logic [15:0] usb_data_fifo_wr_din;
   logic [1:0]  grant;
   logic        busy;
   logic        packet_done;

   always #5 clk = ~clk;

   scurve_usb_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .src_enable           (src_enable),
      .src0_fifo_empty      (src0_fifo_empty),
      .src1_fifo_empty      (src1_fifo_empty),
      .src0_fifo_dout       (src0_fifo_dout),
      .src1_fifo_dout       (src1_fifo_dout),
      .src0_fifo_rd_en      (src0_fifo_rd_en),
      .src1_fifo_rd_en      (src1_fifo_rd_en),
      .usb_data_fifo_full   (usb_data_fifo_full),
      .usb_data_fifo_wr_en  (usb_data_fifo_wr_en),
      .usb_data_fifo_wr_din (usb_data_fifo_wr_din),
      .grant                (grant),
      .busy                 (busy),
      .packet_done          (packet_done)
   );

   // Source FIFO models: standard read, data valid the cycle after rd_en.
   logic [15:0] mem0 [0:4095];
   logic [15:0] mem1 [0:4095];
   int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

   assign src0_fifo_empty = (rp0 == wp0);
   assign src1_fifo_empty = (rp1 == wp1);

   always @(posedge clk) begin
      if (src0_fifo_rd_en) begin
         src0_fifo_dout <= mem0[rp0[11:0]];
         rp0 <= rp0 + 1;
      end
      if (src1_fifo_rd_en) begin
         src1_fifo_dout <= mem1[rp1[11:0]];
         rp1 <= rp1 + 1;
      end
   end

   // USB FIFO model: log every accepted write; count protocol violations.
   logic [15:0] usb_log [0:4095];
   int usb_n = 0;
   int viol  = 0;

   always @(posedge clk) begin
      if (usb_data_fifo_wr_en) begin
         usb_log[usb_n[11:0]] <= usb_data_fifo_wr_din;
         usb_n <= usb_n + 1;
      end
      if ((usb_data_fifo_full && (usb_data_fifo_wr_en || src0_fifo_rd_en || src1_fifo_rd_en)) ||
          (src0_fifo_rd_en && (src0_fifo_empty || grant != 2'b01)) ||
          (src1_fifo_rd_en && (src1_fifo_empty || grant != 2'b10)))
         viol <= viol + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit toggle_full = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int idx, input logic [15:0] exp);
      check(tag, {16'h0000, usb_log[idx[11:0]]}, {16'h0000, exp});
   endtask

   // Advance to the middle of the next cycle; inputs set after this apply to that cycle.
   task automatic step();
      @(negedge clk);
      if (toggle_full) usb_data_fifo_full = ~usb_data_fifo_full;
      #1;
   endtask

   task automatic push0(input logic [15:0] w);
      mem0[wp0[11:0]] = w;
      wp0++;
   endtask

   task automatic push1(input logic [15:0] w);
      mem1[wp1[11:0]] = w;
      wp1++;
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (!(usb_n >= target && !busy) && n < budget) begin
         step();
         n++;
      end
      check(tag, {31'd0, n < budget}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  {31'd0, busy},                 32'd0);
      check({tag, "_grant"}, {30'd0, grant},                32'd0);
      check({tag, "_done"},  {31'd0, packet_done},          32'd0);
      check({tag, "_wr"},    {31'd0, usb_data_fifo_wr_en},  32'd0);
      check({tag, "_rd"},    {30'd0, src1_fifo_rd_en, src0_fifo_rd_en}, 32'd0);
      check({tag, "_din"},   {16'd0, usb_data_fifo_wr_din}, 32'd0);
   endtask

   initial begin
      int start, cyc, idx, off0, off1;

      rst = 1'b1;
      src_enable = 2'b00;
      usb_data_fifo_full = 1'b0;
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // 3-word packet from source 0; trailer in cycle N+3 = 6
      step();
      src_enable = 2'b11;
      push0(16'h1111); push0(16'h2222); push0(16'h3333);
      #1;
      start = usb_n;
      cyc = 0;
      check("t1_idle_busy", {31'd0, busy}, 32'd0);
      do begin
         step();
         cyc++;
         if (cyc == 1) begin
            check("t1_c1_grant", {30'd0, grant}, 32'd1);
            check("t1_c1_busy",  {31'd0, busy},  32'd1);
            check("t1_c1_hdr",   {16'd0, usb_data_fifo_wr_din}, 32'hA5A0);
         end
         if (cyc == 2) check("t1_c2_rd", {31'd0, src0_fifo_rd_en}, 32'd1);
      end while (!packet_done && cyc < 20);
      check("t1_done_cycle", cyc, 32'd6);
      check("t1_trailer_din", {16'd0, usb_data_fifo_wr_din}, 32'hF003);
      step();
      check("t1_idle_after", {31'd0, busy}, 32'd0);
      check_log("t1_w0", start,     16'hA5A0);
      check_log("t1_w1", start + 1, 16'h1111);
      check_log("t1_w2", start + 2, 16'h2222);
      check_log("t1_w3", start + 3, 16'h3333);
      check_log("t1_w4", start + 4, 16'hF003);
      check("t1_count", usb_n - start, 32'd5);

      // Fresh reset so source 0 wins the first tie; 600 words each, BURST_MAX 256
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
         push0(16'h1000 + 16'(i));
         push1(16'h2000 + 16'(i));
      end
      #1;
      start = usb_n;
      wait_done("t2_timeout", start + 1212, 5000);
      check("t2_count", usb_n - start, 32'd1212);
      idx = start;
      off0 = 0;
      off1 = 0;
      for (int p = 0; p < 6; p++) begin
         int s, n;
         s = p % 2;
         n = (p < 4) ? 256 : 88;
         check_log("t2_hdr", idx, (s == 1) ? 16'hA5A1 : 16'hA5A0);
         idx++;
         for (int k = 0; k < n; k++) begin
            check_log("t2_data", idx, (s == 1) ? 16'h2000 + 16'(off1 + k) : 16'h1000 + 16'(off0 + k));
            idx++;
         end
         check_log("t2_trl", idx, 16'hF000 | 16'(n));
         idx++;
         if (s == 1) off1 += n; else off0 += n;
      end

      // Full for 5 cycles right after the first rd_en of a 4-word packet
      step();
      push0(16'h3331); push0(16'h3332); push0(16'h3333); push0(16'h3334);
      #1;
      start = usb_n;
      step();
      check("t3_c1_hdr", {16'd0, usb_data_fifo_wr_din}, 32'hA5A0);
      step();
      check("t3_c2_rd", {31'd0, src0_fifo_rd_en}, 32'd1);
      step();
      usb_data_fifo_full = 1'b1;
      #1;
      check("t3_c3_wr", {31'd0, usb_data_fifo_wr_en}, 32'd0);
      check("t3_c3_rd", {31'd0, src0_fifo_rd_en}, 32'd0);
      for (int i = 0; i < 4; i++) step();
      step();
      usb_data_fifo_full = 1'b0;
      #1;
      check("t3_c8_wr",  {31'd0, usb_data_fifo_wr_en}, 32'd1);
      check("t3_c8_din", {16'd0, usb_data_fifo_wr_din}, 32'h3331);
      check("t3_c8_rd",  {31'd0, src0_fifo_rd_en}, 32'd0);
      step();
      check("t3_c9_rd",  {31'd0, src0_fifo_rd_en}, 32'd1);
      wait_done("t3_timeout", start + 6, 100);
      check("t3_count", usb_n - start, 32'd6);
      check_log("t3_w0", start,     16'hA5A0);
      check_log("t3_w1", start + 1, 16'h3331);
      check_log("t3_w2", start + 2, 16'h3332);
      check_log("t3_w3", start + 3, 16'h3333);
      check_log("t3_w4", start + 4, 16'h3334);
      check_log("t3_w5", start + 5, 16'hF004);

      // Full toggling every cycle for a 32-word packet
      step();
      for (int i = 0; i < 32; i++) push0(16'h6000 + 16'(i));
      toggle_full = 1'b1;
      #1;
      start = usb_n;
      wait_done("t4_timeout", start + 34, 500);
      toggle_full = 1'b0;
      usb_data_fifo_full = 1'b0;
      step();
      check("t4_count", usb_n - start, 32'd34);
      check_log("t4_hdr", start, 16'hA5A0);
      for (int i = 0; i < 32; i++) check_log("t4_data", start + 1 + i, 16'h6000 + 16'(i));
      check_log("t4_trl", start + 33, 16'hF020);

      // Reset in the cycle of the 2nd data write; source 0 then wins the tie
      step();
      push0(16'h4441); push0(16'h4442); push0(16'h4443); push0(16'h4444);
      #1;
      start = usb_n;
      step();
      step();
      step();
      step();
      rst = 1'b1;
      push1(16'h5551); push1(16'h5552);
      #1;
      check("t5_c4_wr",  {31'd0, usb_data_fifo_wr_en}, 32'd1);
      check("t5_c4_din", {16'd0, usb_data_fifo_wr_din}, 32'h4442);
      step();
      rst = 1'b0;
      #1;
      check_reset_outputs("t5_after_rst");
      step();
      check("t5_tie_grant", {30'd0, grant}, 32'd1);
      check("t5_tie_hdr",   {16'd0, usb_data_fifo_wr_din}, 32'hA5A0);
      wait_done("t5_timeout", start + 10, 200);
      check("t5_count", usb_n - start, 32'd10);
      check_log("t5_w1", start + 1, 16'h4441);
      check_log("t5_w2", start + 2, 16'h4442);
      check_log("t5_w3", start + 3, 16'hA5A0);
      check_log("t5_w4", start + 4, 16'h4444);
      check_log("t5_w5", start + 5, 16'hF001);
      check_log("t5_w6", start + 6, 16'hA5A1);
      check_log("t5_w7", start + 7, 16'h5551);
      check_log("t5_w8", start + 8, 16'h5552);
      check_log("t5_w9", start + 9, 16'hF002);

      // Source 1 disabled; source 0 disabled mid-packet still completes
      step();
      src_enable = 2'b01;
      push0(16'h7771); push0(16'h7772); push0(16'h7773);
      push1(16'h8881); push1(16'h8882); push1(16'h8883);
      #1;
      start = usb_n;
      step();
      check("t6_grant", {30'd0, grant}, 32'd1);
      step();
      step();
      src_enable = 2'b00;
      #1;
      wait_done("t6_timeout", start + 5, 100);
      for (int i = 0; i < 10; i++) step();
      check("t6_count", usb_n - start, 32'd5);
      check("t6_busy",  {31'd0, busy}, 32'd0);
      check_log("t6_w0", start,     16'hA5A0);
      check_log("t6_w1", start + 1, 16'h7771);
      check_log("t6_w3", start + 3, 16'h7773);
      check_log("t6_w4", start + 4, 16'hF003);
      check("t6_src1_untouched", wp1 - rp1, 32'd3);

      check("protocol_violations", viol, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scurve_usb_arbiter.md
# scurve_usb_arbiter

Packet-framing write arbiter between two 16-bit source FIFOs and the single USB data FIFO. Source 0 is the S-curve data stream (the SCurve test controller output) and source 1 is the auxiliary/housekeeping stream. The arbiter grants one source at a time with round-robin fairness at packet boundaries. Each burst is wrapped in a header word and a trailer word carrying the word count. The USB FIFO full flag is respected through a one-word skid register.

## Interface
- BURST_MAX, 256: maximum data words per packet; legal range 1..4095.
- HDR_TAG, 16'hA5A0: header base; header = {HDR_TAG[15:1], src_id}.
- Clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; **one clock; reset is synchronous and active-high**.
- src_enable  in  2  per-source request enable; sampled only in IDLE.
- src0_fifo_empty / src1_fifo_empty  in  1  source FIFO empty.
- src0_fifo_dout / src1_fifo_dout  in  16  source FIFO data, valid the cycle after rd_en (standard read, latency 1).
- src0_fifo_rd_en / src1_fifo_rd_en  out  1  source FIFO read strobe.
- usb_data_fifo_full  in  1  USB FIFO full.
- usb_data_fifo_wr_en  out  1  USB FIFO write strobe.
- usb_data_fifo_wr_din  out  16  USB FIFO write data.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- busy  out  1  high in every state except IDLE.
- packet_done  out  1  one-cycle pulse, coincident with the trailer write.

## Operation
- States: IDLE, HEADER, READ, TRAILER.
- Request: req[i] = src_enable[i] & ~srci_fifo_empty.
- IDLE transitions:
  - No request: stay in IDLE.
  - One request: grant that source.
  - Both request: grant the source that is not last_grant.
  - On a grant: clear counters, go to HEADER.
- HEADER:
  - Write {HDR_TAG[15:1], src_id} when usb_data_fifo_full=0, then go to READ.
  - While full=1: hold, no write.
- READ issue rule: assert the granted rd_en in a cycle only if all hold:
  - source not empty;
  - issued < BURST_MAX;
  - usb_data_fifo_full=0;
  - skid register empty.
- Returned word (arrives one cycle after rd_en):
  - written directly if full=0;
  - otherwise loaded into the skid register.
- Skid register drains when full=0. While it is occupied, no rd_en is issued.
- Issuing stops permanently for this packet when issued=BURST_MAX or when the source is empty in an issue-eligible cycle.
- READ → TRAILER when issuing has stopped, no word is in flight, the skid is empty, and the last data write has completed.
- TRAILER:
  - Write {4'hF, written[11:0]} when full=0.
  - Pulse packet_done in the same cycle.
  - last_grant ← current source; go to IDLE.
- Counters: issued and written are 12 bits each; written equals the number of data words placed in the USB FIFO. A packet always has ≥1 data word, because only the arbiter reads the sources.
- src_enable deasserted mid-packet has no effect until IDLE; the packet completes normally.
- usb_data_fifo_wr_en and the rd_en outputs are combinational from state, registers and usb_data_fifo_full. Never write while full=1. Never read from the non-granted source.

## Timing
- Reset values:
  - State IDLE, grant=0, busy=0, packet_done=0.
  - All rd_en/wr_en 0, wr_din 16'h0000.
  - last_grant=1, so source 0 wins the first tie.
  - Skid empty; counters 0.
- rst mid-packet: abort immediately and discard any in-flight or skid word. Downstream then sees a header with no trailer; this is accepted behaviour.
- No backpressure, packet of N words. Cycle 0 = IDLE cycle with a request:
  - grant/busy high from cycle 1;
  - header written in cycle 1;
  - rd_en in cycles 2..N+1;
  - data writes in cycles 3..N+2;
  - trailer and packet_done in cycle N+3;
  - IDLE in cycle N+4, where the next arbitration may occur.
- Each cycle of full=1 in HEADER/READ/TRAILER stretches the packet by at least one cycle. No word is lost or duplicated.
- Full asserting the cycle after a rd_en: the word is held in the skid and written on the first cycle with full=0. The next rd_en follows one cycle after that write at the earliest.

## Test plan
- Source 0 holds 3 words (0x1111, 0x2222, 0x3333), source 1 empty, HDR_TAG default → USB receives 0xA5A0, 0x1111, 0x2222, 0x3333, 0xF003. Trailer and packet_done in cycle 6.
- Both sources hold 600 words, BURST_MAX=256 → packet order src0(256), src1(256), src0(256), src1(256), src0(88), src1(88). Headers are 0xA5A0/0xA5A1; trailers are 0xF100 ×4, then 0xF058 ×2.
- Full asserted for 5 cycles immediately after the first rd_en of a 4-word packet → skid captures word 1. No rd_en issues while full, and no write occurs while full. Output is exact and in order, with trailer 0xF004.
- Full toggling every other cycle for a 32-word packet → 34 writes total with no loss or duplication. wr_en is never high while full=1.
- rst pulsed in the cycle of the 2nd data write → next cycle all outputs are at reset values. The next request restarts with a fresh header and source 0 wins the tie.
- src_enable[1]=0 with both sources non-empty → only source 0 is served. Clearing src_enable[0] mid-packet still yields a complete trailer.
